// File: rtl/max7219_frame_sender.sv
// max7219_frame_sender: SPI master that configures a MAX7219 after reset/reinit and streams one register write per digit on each frame request.
module max7219_frame_sender #(
  parameter int         NUM_DIGITS  = 6,
  parameter int         CLK_DIV     = 4,
  parameter logic [3:0] INTENSITY   = 4'h8,
  parameter logic [7:0] DECODE_MASK = 8'hFF
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    ena,
  input  logic                    frame_req,
  input  logic                    reinit,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic                    busy,
  output logic                    init_done,
  output logic                    frame_done,
  output logic                    MOSI,
  output logic                    CS,
  output logic                    clk_SPI
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [2:0] LAST_DIG = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {INIT_WAIT, INIT_SEND, IDLE, FRAME_SEND} state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           div_q, div_d;
  logic [5:0]              slot_q, slot_d;
  logic [2:0]              word_q, word_d;
  logic                    frame_pend_q, frame_pend_d;
  logic                    reinit_pend_q, reinit_pend_d;
  logic                    init_done_q, init_done_d;
  logic                    frame_done_q, frame_done_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [3:0]              nib [8];
  logic [15:0]             word_w;
  logic [3:0]              bi;
  logic                    sending, word_end, seq_end, init_start, frame_start;

  for (genvar k = 0; k < 8; k++) begin : g_nib
    if (k < NUM_DIGITS) begin : g_on
      assign nib[k] = shadow_q[4*k +: 4];
    end else begin : g_off
      assign nib[k] = 4'h0;
    end
  end

  assign word_w = state_q == FRAME_SEND ? {4'h0, {1'b0, word_q} + 4'h1, 4'h0, nib[word_q]}
                : word_q == 3'd0 ? 16'h0C01
                : word_q == 3'd1 ? 16'h0F00
                : word_q == 3'd2 ? {8'h0B, 5'h00, LAST_DIG}
                : word_q == 3'd3 ? {8'h09, DECODE_MASK}
                : {8'h0A, 4'h0, INTENSITY};

  // slot 0 = setup, odd slots 1..31 = SCK high, even 2..32 = SCK low, 33 = gap
  assign sending     = state_q == INIT_SEND || state_q == FRAME_SEND;
  assign word_end    = sending && slot_q == 6'd33 && div_q == DIV_MAX;
  assign seq_end     = word_end && word_q == (state_q == INIT_SEND ? 3'd4 : LAST_DIG);
  assign init_start  = ena && (state_q == INIT_WAIT || (state_q == IDLE && reinit_pend_q));
  assign frame_start = ena && state_q == IDLE && !reinit_pend_q && frame_pend_q && init_done_q;
  assign bi          = slot_q[5] ? 4'hF : slot_q[4:1];

  assign CS         = !sending || slot_q == 6'd33;
  assign clk_SPI    = sending && slot_q[0] && slot_q != 6'd33;
  assign MOSI       = !CS && word_w[~bi];
  assign busy       = !res && (sending || frame_pend_q || reinit_pend_q || (state_q == INIT_WAIT && ena));
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    slot_d        = slot_q;
    word_d        = word_q;
    shadow_d      = shadow_q;
    frame_pend_d  = frame_req || (frame_pend_q && !frame_start);
    reinit_pend_d = reinit || (reinit_pend_q && !init_start);
    init_done_d   = init_start ? 1'b0 : init_done_q;
    frame_done_d  = 1'b0;
    if (init_start || frame_start) begin
      state_d  = init_start ? INIT_SEND : FRAME_SEND;
      div_d    = '0;
      slot_d   = '0;
      word_d   = '0;
      shadow_d = frame_start ? digits : shadow_q;
    end else if (sending) begin
      div_d  = div_q == DIV_MAX ? '0 : div_q + DW'(1);
      slot_d = div_q == DIV_MAX ? (slot_q == 6'd33 ? 6'd0 : slot_q + 6'd1) : slot_q;
      word_d = word_end ? word_q + 3'd1 : word_q;
      if (seq_end) begin
        state_d      = IDLE;
        init_done_d  = state_q == INIT_SEND ? 1'b1 : init_done_q;
        frame_done_d = state_q == FRAME_SEND;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q       <= INIT_WAIT;
      div_q         <= '0;
      slot_q        <= '0;
      word_q        <= '0;
      shadow_q      <= '0;
      frame_pend_q  <= 1'b0;
      reinit_pend_q <= 1'b0;
      init_done_q   <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      slot_q        <= slot_d;
      word_q        <= word_d;
      shadow_q      <= shadow_d;
      frame_pend_q  <= frame_pend_d;
      reinit_pend_q <= reinit_pend_d;
      init_done_q   <= init_done_d;
      frame_done_q  <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_max7219_frame_sender.sv
// tb_max7219_frame_sender: scoreboard bench; dut0 uses the default 6 digits / CLK_DIV=4, dut1 uses 1 digit / CLK_DIV=1.
module tb_max7219_frame_sender;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  res_s = 2'b11, ena_s = 2'b00, freq_s = 2'b00, rein_s = 2'b00;
  logic [1:0]  busy_s, idone_s, fd_s, mosi_s, cs_s, sck_s;
  logic [23:0] dig0 = '0;
  logic [3:0]  dig1 = '0;
  int          n_run = 0, n_fail = 0, cyc = 0;
  int          wr_p [2] = '{0, 0};
  int          rd_p [2] = '{0, 0};
  int          nb [2], wis [2], seq_start [2], low_start [2];
  logic [15:0] exp_mem [2][64];
  logic [15:0] sh [2];
  logic [1:0]  pcs = 2'b11, psck = 2'b00, pid = 2'b00, pfd = 2'b00;

  max7219_frame_sender #(.NUM_DIGITS(6), .CLK_DIV(4), .INTENSITY(4'h8), .DECODE_MASK(8'hFF)) dut0 (
    .clk(clk), .res(res_s[0]), .ena(ena_s[0]), .frame_req(freq_s[0]), .reinit(rein_s[0]),
    .digits(dig0), .busy(busy_s[0]), .init_done(idone_s[0]), .frame_done(fd_s[0]),
    .MOSI(mosi_s[0]), .CS(cs_s[0]), .clk_SPI(sck_s[0]));

  max7219_frame_sender #(.NUM_DIGITS(1), .CLK_DIV(1), .INTENSITY(4'h8), .DECODE_MASK(8'hFF)) dut1 (
    .clk(clk), .res(res_s[1]), .ena(ena_s[1]), .frame_req(freq_s[1]), .reinit(rein_s[1]),
    .digits(dig1), .busy(busy_s[1]), .init_done(idone_s[1]), .frame_done(fd_s[1]),
    .MOSI(mosi_s[1]), .CS(cs_s[1]), .clk_SPI(sck_s[1]));

  function automatic int dv(int i); return i == 0 ? 4 : 1; endfunction
  function automatic int nd(int i); return i == 0 ? 6 : 1; endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // reference model: the word list a MAX7219 should receive for each sequence
  function automatic void push(int i, logic [15:0] w);
    exp_mem[i][wr_p[i] % 64] = w;
    wr_p[i]++;
  endfunction
  function automatic void push_cfg(int i);
    push(i, 16'h0C01); push(i, 16'h0F00); push(i, {8'h0B, 8'(nd(i) - 1)});
    push(i, 16'h09FF); push(i, 16'h0A08);
  endfunction
  function automatic void push_frame(int i, logic [31:0] d);
    for (int k = 0; k < nd(i); k++) push(i, {4'h0, 4'(k + 1), 4'h0, 4'(d >> (4 * k))});
  endfunction

  // monitor: decodes SPI words and sequence timing, pops the scoreboard
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (res_s[i]) begin
        rd_p[i] = wr_p[i];
        nb[i] = 0;
        wis[i] = 0;
      end else begin
        if (!cs_s[i] && pcs[i]) begin
          low_start[i] = cyc;
          nb[i] = 0;
          if (wis[i] == 0) seq_start[i] = cyc;
          wis[i]++;
        end
        if (!cs_s[i] && sck_s[i] && !psck[i]) begin
          sh[i] = {sh[i][14:0], mosi_s[i]};
          nb[i]++;
        end
        if (cs_s[i] && !pcs[i]) begin
          chk($sformatf("dut%0d rising SCK edges per word", i), nb[i], 16);
          chk($sformatf("dut%0d CS low cycles", i), cyc - low_start[i], 33 * dv(i));
          chk($sformatf("dut%0d gap SCK/MOSI", i), {sck_s[i], mosi_s[i]}, 0);
          if (rd_p[i] == wr_p[i]) begin
            n_run++;
            n_fail++;
            $display("FAIL dut%0d unexpected word: got %h expected none", i, sh[i]);
          end else begin
            chk($sformatf("dut%0d word %0d", i, rd_p[i]), sh[i], exp_mem[i][rd_p[i] % 64]);
            rd_p[i]++;
          end
        end
        if (idone_s[i] && !pid[i]) begin
          chk($sformatf("dut%0d init_done latency", i), cyc - seq_start[i], 170 * dv(i));
          wis[i] = 0;
        end
        if (fd_s[i] && !pfd[i]) begin
          chk($sformatf("dut%0d frame_done latency", i), cyc - seq_start[i], 34 * nd(i) * dv(i));
          wis[i] = 0;
        end
        if (pfd[i]) chk($sformatf("dut%0d frame_done width", i), fd_s[i], 0);
      end
      pcs[i] = cs_s[i];
      psck[i] = sck_s[i];
      pid[i] = idone_s[i];
      pfd[i] = fd_s[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(int i, int s);
    return s == 0 ? cs_s[i] : s == 1 ? idone_s[i] : s == 2 ? fd_s[i] : busy_s[i];
  endfunction

  task automatic wait_for(input int i, input int s, input logic v, input int lim, input string nm);
    int c = 0;
    while (sig(i, s) !== v && c < lim) begin
      step();
      c++;
    end
    if (sig(i, s) !== v) chk($sformatf("timeout %s", nm), sig(i, s), v);
  endtask

  task automatic pulse(input int i, input logic f, input logic r);
    freq_s[i] = f;
    rein_s[i] = r;
    step();
    freq_s[i] = 1'b0;
    rein_s[i] = 1'b0;
  endtask

  task automatic run0();
    logic [23:0] d;
    int bl, fdc, c;
    res_s[0] = 1'b1;
    ena_s[0] = 1'b1;
    repeat (3) step();
    chk("dut0 reset outputs", {cs_s[0], sck_s[0], mosi_s[0], busy_s[0], idone_s[0], fd_s[0]}, 6'b100000);
    res_s[0] = 1'b0;
    push_cfg(0);
    wait_for(0, 1, 1'b1, 2000, "dut0 init");
    wait_for(0, 3, 1'b0, 50, "dut0 idle");
    dig0 = 24'h123456;
    push_frame(0, 24'h123456);
    pulse(0, 1'b1, 1'b0);
    wait_for(0, 0, 1'b0, 20, "frame1 start");
    d = 24'($urandom);
    dig0 = d;
    push_frame(0, d);
    bl = 0;
    fdc = 0;
    for (int k = 0; k < 3000; k++) begin
      step();
      freq_s[0] = (k == 100 || k == 300 || k == 500);
      if (fd_s[0]) begin
        fdc++;
        if (fdc == 2) break;
      end
      if (!busy_s[0]) bl++;
    end
    freq_s[0] = 1'b0;
    chk("busy low cycles across queued frames", bl, 0);
    chk("frames completed for 3 queued requests", fdc, 2);
    repeat (40) step();
    chk("dut0 scoreboard drained after queued frames", wr_p[0] - rd_p[0], 0);
    chk("dut0 busy after queued frames", busy_s[0], 0);
    repeat (4) begin
      repeat ($urandom_range(0, 15)) step();
      d = 24'($urandom);
      dig0 = d;
      push_frame(0, d);
      pulse(0, 1'b1, 1'b0);
      wait_for(0, 0, 1'b0, 20, "random frame start");
      dig0 = 24'($urandom);
      wait_for(0, 2, 1'b1, 1000, "random frame done");
    end
    ena_s[0] = 1'b0;
    d = 24'($urandom);
    dig0 = d;
    push_frame(0, d);
    pulse(0, 1'b1, 1'b0);
    bl = 0;
    repeat (200) begin
      step();
      if (!cs_s[0]) bl++;
    end
    chk("CS low cycles while ena=0", bl, 0);
    chk("busy with latched request and ena=0", busy_s[0], 1);
    ena_s[0] = 1'b1;
    wait_for(0, 0, 1'b0, 20, "held frame start");
    wait_for(0, 2, 1'b1, 1000, "held frame done");
    repeat (5) step();
    d = 24'($urandom);
    dig0 = d;
    push_cfg(0);
    push_frame(0, d);
    pulse(0, 1'b1, 1'b1);
    wait_for(0, 0, 1'b0, 20, "reinit start");
    chk("init_done during resend", idone_s[0], 0);
    wait_for(0, 1, 1'b1, 2000, "reinit done");
    wait_for(0, 2, 1'b1, 1000, "frame after reinit");
    repeat (5) step();
    d = 24'($urandom);
    dig0 = d;
    pulse(0, 1'b1, 1'b0);
    wait_for(0, 0, 1'b0, 20, "abandoned frame start");
    step();
    c = 0;
    while (nb[0] < 8 && c < 200) begin
      step();
      c++;
    end
    chk("bits sent before mid-word reset", nb[0], 8);
    res_s[0] = 1'b1;
    step();
    chk("dut0 outputs after mid-word reset", {cs_s[0], sck_s[0], mosi_s[0], busy_s[0], idone_s[0], fd_s[0]}, 6'b100000);
    step();
    res_s[0] = 1'b0;
    push_cfg(0);
    push_frame(0, d);
    pulse(0, 1'b1, 1'b0);
    wait_for(0, 1, 1'b1, 2000, "init after reset");
    wait_for(0, 2, 1'b1, 1000, "frame after reset");
    wait_for(0, 3, 1'b0, 50, "final idle");
    chk("dut0 scoreboard drained", wr_p[0] - rd_p[0], 0);
  endtask

  task automatic run1();
    logic [3:0] d;
    res_s[1] = 1'b1;
    ena_s[1] = 1'b1;
    repeat (3) step();
    chk("dut1 reset outputs", {cs_s[1], sck_s[1], mosi_s[1], busy_s[1], idone_s[1], fd_s[1]}, 6'b100000);
    res_s[1] = 1'b0;
    push_cfg(1);
    wait_for(1, 1, 1'b1, 500, "dut1 init");
    repeat (2) begin
      d = 4'($urandom);
      dig1 = d;
      push_frame(1, {28'h0, d});
      pulse(1, 1'b1, 1'b0);
      wait_for(1, 2, 1'b1, 200, "dut1 frame");
      repeat (3) step();
    end
    chk("dut1 scoreboard drained", wr_p[1] - rd_p[1], 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    fork
      run0();
      run1();
    join
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
